// File: rtl/axi_rd_port_arbiter_pkg.sv
// axi_rd_port_arbiter_pkg
//   Shared definitions for the m00_axi read-port arbiter: the fixed AR
//   attribute encodings, the OKAY response code, the arbiter FSM state type
//   and a small index-wrap helper used by the round-robin picker.
package axi_rd_port_arbiter_pkg;

  localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;
  localparam logic [2:0] AXI_PROT_DEF   = 3'b000;
  localparam logic       AXI_LOCK_DEF   = 1'b0;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } arb_state_e;

  // Index reached by stepping 'off' places past 'base' in a ring of 'n'.
  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/axi_rd_port_arbiter_if.sv
// axi_rd_port_arbiter_if
//   AXI4 read channel (AR + R) bundle between the arbiter and the memory side.
//   master : drives AR and rready (the arbiter)
//   slave  : drives arready and the R beat (axi_ram / DDR model)
interface axi_rd_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512,
  parameter int LEN_W  = 8
);
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_port_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick. Searches the request vector starting one
//   position after last_grant and wrapping, returning the first set index.
//   Ports: req (request vector), last_grant (pointer, held by the parent),
//          grant (one-hot), grant_idx (binary index), grant_any (any request).
module rr_arbiter
  import axi_rd_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  int cand_s;

  // First requester after the pointer wins; the pointer itself is checked last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand_s    = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_s = wrap_idx(int'(last_grant), off, NUM_REQ);
      if (!grant_any && req[cand_s]) begin
        grant_any     = 1'b1;
        grant_idx     = IDX_W'(cand_s);
        grant[cand_s] = 1'b1;
      end else begin
        grant_any = grant_any;
      end
    end
  end

endmodule

// File: rtl/axi_rd_port_arbiter.sv
// axi_rd_port_arbiter
//   Shares one m00_axi read channel between NUM_REQ loaders. One burst is in
//   flight at a time: a round-robin winner is accepted in IDLE (req_ready
//   pulse), its address/length go out on AR, and R beats are steered back to
//   that loader until rlast.
//   Ports: system_clk / rst_n (async, active-low)
//          req_valid/req_ready/req_addr/req_len : loader request side
//          rd_valid/rd_ready/rd_data/rd_last    : loader read-beat side
//          m00_axi                              : AXI read master
//          busy (burst in progress), err (sticky protocol/response error)
module axi_rd_port_arbiter
  import axi_rd_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 512,
  parameter int LEN_W   = 8
) (
  input  logic                      system_clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        rd_valid,
  input  logic [NUM_REQ-1:0]        rd_ready,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_last,
  axi_rd_port_arbiter_if.master     m00_axi,
  output logic                      busy,
  output logic                      err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          state_r;
  arb_state_e          state_nxt_s;
  logic [IDX_W-1:0]    grant_idx_r;
  logic [IDX_W-1:0]    last_grant_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [LEN_W-1:0]    len_r;
  logic [LEN_W:0]      beat_cnt_r;
  logic                err_r;

  logic [NUM_REQ-1:0]  pick_onehot_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic                pick_any_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [LEN_W-1:0]    sel_len_s;
  logic                accept_s;
  logic                beat_s;
  logic                resp_bad_s;
  logic                len_bad_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .grant      (pick_onehot_s),
    .grant_idx  (pick_idx_s),
    .grant_any  (pick_any_s)
  );

  // Select the winning loader's address/length slice.
  always_comb begin
    sel_addr_s = '0;
    sel_len_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx_s == IDX_W'(i)) begin
        sel_addr_s = req_addr[i*ADDR_W +: ADDR_W];
        sel_len_s  = req_len[i*LEN_W +: LEN_W];
      end else begin
        sel_addr_s = sel_addr_s;
      end
    end
  end

  // FSM next-state and request acceptance.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_ADDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (m00_axi.arready) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (beat_s && m00_axi.rlast) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // R steering: only the granted loader sees rvalid, and only its ready gates rready.
  always_comb begin
    rd_valid = '0;
    if (state_r == ST_DATA) begin
      rd_valid[grant_idx_r] = m00_axi.rvalid;
    end else begin
      rd_valid = '0;
    end
  end

  assign m00_axi.rready = (state_r == ST_DATA) && rd_ready[grant_idx_r];
  assign beat_s         = m00_axi.rvalid && m00_axi.rready;
  assign resp_bad_s     = (m00_axi.rresp != AXI_RESP_OKAY);
  // rlast is correct only on beat index len (i.e. counter+1 == len+1).
  assign len_bad_s      = m00_axi.rlast && (beat_cnt_r != {1'b0, len_r});

  // FSM state register.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Burst context: latched on acceptance, beat counter and pointer advanced on beats.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_idx_r  <= '0;
      addr_r       <= '0;
      len_r        <= '0;
      beat_cnt_r   <= '0;
      last_grant_r <= IDX_W'(NUM_REQ - 1);
    end else if (accept_s) begin
      grant_idx_r <= pick_idx_s;
      addr_r      <= sel_addr_s;
      len_r       <= sel_len_s;
      beat_cnt_r  <= '0;
    end else if (beat_s) begin
      if (m00_axi.rlast) begin
        beat_cnt_r   <= '0;
        last_grant_r <= grant_idx_r;
      end else begin
        beat_cnt_r <= beat_cnt_r + 1'b1;
      end
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (beat_s && (resp_bad_s || len_bad_s)) begin
      err_r <= 1'b1;
    end
  end

  assign req_ready       = accept_s ? pick_onehot_s : '0;
  assign m00_axi.arvalid = (state_r == ST_ADDR);
  assign m00_axi.araddr  = addr_r;
  assign m00_axi.arlen   = len_r;
  assign m00_axi.arsize  = AXI_SIZE_64B;
  assign m00_axi.arburst = AXI_BURST_INCR;
  assign m00_axi.arlock  = AXI_LOCK_DEF;
  assign m00_axi.arcache = AXI_CACHE_DEF;
  assign m00_axi.arprot  = AXI_PROT_DEF;
  assign rd_data         = m00_axi.rdata;
  assign rd_last         = m00_axi.rlast;
  assign busy            = (state_r != ST_IDLE);
  assign err             = err_r;

endmodule
